// File: rtl/regfile_scoreboard.sv
// Register file with write-to-read bypass and a per-register busy
// scoreboard for RAW hazard detection at issue.
module regfile_scoreboard #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1,
  localparam int DEPTH   = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_busy_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              flush,
  output logic [DEPTH-1:0]  busy_vec,
  output logic [ADDR_W:0]   busy_cnt
);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              wr_ok, rsv_ok;

  // Hardwired R0 swallows writes and reservations entirely.
  assign wr_ok  = wr_en &&
                  !(ZERO_REG && wr_addr == '0);
  assign rsv_ok = rsv_en &&
                  !(ZERO_REG && rsv_addr == '0);

  always_comb begin
    busy_d = flush ? '0 : busy_q;
    if (wr_ok)
      busy_d[wr_addr] = 1'b0;
    if (rsv_ok)
      busy_d[rsv_addr] = 1'b1;
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_ok)
        regs_q[wr_addr] <= wr_data;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    rd_busy_a = busy_q[rd_addr_a];
    if (ZERO_REG && rd_addr_a == '0) begin
      rd_data_a = '0;
      rd_busy_a = 1'b0;
    end else if (BYPASS && wr_ok &&
                 wr_addr == rd_addr_a) begin
      rd_data_a = wr_data;
      rd_busy_a = 1'b0;
    end
  end

  always_comb begin
    rd_data_b = regs_q[rd_addr_b];
    rd_busy_b = busy_q[rd_addr_b];
    if (ZERO_REG && rd_addr_b == '0) begin
      rd_data_b = '0;
      rd_busy_b = 1'b0;
    end else if (BYPASS && wr_ok &&
                 wr_addr == rd_addr_b) begin
      rd_data_b = wr_data;
      rd_busy_b = 1'b0;
    end
  end

  assign busy_vec = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: default, no-bypass and zero-reg instances share
// one stimulus stream.
module tb_regfile_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] rd_addr_a, rd_addr_b;
  logic       wr_en, rsv_en, flush;
  logic [1:0] wr_addr, rsv_addr;
  logic [7:0] wr_data;

  logic [7:0] d_da, d_db, n_da, n_db, z_da, z_db;
  logic       d_ba, d_bb, n_ba, n_bb, z_ba, z_bb;
  logic [3:0] d_bv, n_bv, z_bv;
  logic [2:0] d_bc, n_bc, z_bc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(
    .DATA_W(8), .ADDR_W(2),
    .ZERO_REG(1'b0), .BYPASS(1'b1)
  ) u_dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_data_a(d_da),
    .rd_busy_a(d_ba),
    .rd_addr_b(rd_addr_b), .rd_data_b(d_db),
    .rd_busy_b(d_bb),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .flush(flush),
    .busy_vec(d_bv), .busy_cnt(d_bc)
  );

  regfile_scoreboard #(
    .DATA_W(8), .ADDR_W(2),
    .ZERO_REG(1'b0), .BYPASS(1'b0)
  ) u_nb (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_data_a(n_da),
    .rd_busy_a(n_ba),
    .rd_addr_b(rd_addr_b), .rd_data_b(n_db),
    .rd_busy_b(n_bb),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .flush(flush),
    .busy_vec(n_bv), .busy_cnt(n_bc)
  );

  regfile_scoreboard #(
    .DATA_W(8), .ADDR_W(2),
    .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) u_z (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_data_a(z_da),
    .rd_busy_a(z_ba),
    .rd_addr_b(rd_addr_b), .rd_data_b(z_db),
    .rd_busy_b(z_bb),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .flush(flush),
    .busy_vec(z_bv), .busy_cnt(z_bc)
  );

  task automatic idle();
    wr_en = 0; rsv_en = 0; flush = 0;
    wr_addr = 0; rsv_addr = 0; wr_data = 0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; idle();
    rd_addr_a = 0; rd_addr_b = 0;
    #12;
    for (int i = 0; i < 4; i++) begin
      rd_addr_a = 2'(i); rd_addr_b = 2'(3 - i);
      #1;
      checks++;
      if (d_da !== 8'h00 || d_db !== 8'h00 ||
          d_ba !== 1'b0 || d_bb !== 1'b0) begin
        failures++;
        $display("FAIL reset_read[%0d] got %h/%h %b/%b want 00/00 0/0",
                 i, d_da, d_db, d_ba, d_bb);
      end
    end
    checks++;
    if (d_bc !== 3'd0 || d_bv !== 4'b0000) begin
      failures++;
      $display("FAIL reset_busy got vec=%b cnt=%0d want 0000/0",
               d_bv, d_bc);
    end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_bypass();
    rd_addr_a = 2; wr_en = 1; wr_addr = 2; wr_data = 8'hA5;
    #1;
    checks++;
    if (d_da !== 8'hA5 || d_ba !== 1'b0) begin
      failures++;
      $display("FAIL bypass_same got %h want a5", d_da);
    end
    checks++;
    if (n_da !== 8'h00) begin
      failures++;
      $display("FAIL nobypass_same got %h want 00", n_da);
    end
    step();
    idle();
    #1;
    checks++;
    if (n_da !== 8'hA5 || d_da !== 8'hA5) begin
      failures++;
      $display("FAIL write_next got nb=%h byp=%h want a5",
               n_da, d_da);
    end
  endtask

  task automatic test_reserve();
    rd_addr_b = 1; rsv_en = 1; rsv_addr = 1;
    step();
    idle();
    #1;
    checks++;
    if (d_bv !== 4'b0010 || d_bb !== 1'b1 ||
        d_bc !== 3'd1) begin
      failures++;
      $display("FAIL rsv_r1 got vec=%b busy=%b cnt=%0d want 0010/1/1",
               d_bv, d_bb, d_bc);
    end
    wr_en = 1; wr_addr = 1; wr_data = 8'h3C;
    #1;
    checks++;
    if (d_bb !== 1'b0 || d_db !== 8'h3C) begin
      failures++;
      $display("FAIL release_byp got busy=%b data=%h want 0/3c",
               d_bb, d_db);
    end
    checks++;
    if (n_bb !== 1'b1 || n_db !== 8'h00) begin
      failures++;
      $display("FAIL release_nobyp got busy=%b data=%h want 1/00",
               n_bb, n_db);
    end
    step();
    idle();
    #1;
    checks++;
    if (d_bv !== 4'b0000 || d_bc !== 3'd0 ||
        d_db !== 8'h3C) begin
      failures++;
      $display("FAIL release_next got vec=%b cnt=%0d data=%h want 0000/0/3c",
               d_bv, d_bc, d_db);
    end
  endtask

  task automatic test_same_edge();
    rsv_en = 1; rsv_addr = 3;
    wr_en = 1; wr_addr = 3; wr_data = 8'h7F;
    step();
    idle();
    rd_addr_a = 3;
    #1;
    checks++;
    if (d_da !== 8'h7F || d_ba !== 1'b1 ||
        d_bv !== 4'b1000 || d_bc !== 3'd1) begin
      failures++;
      $display("FAIL same_edge got %h/%b vec=%b cnt=%0d want 7f/1/1000/1",
               d_da, d_ba, d_bv, d_bc);
    end
  endtask

  task automatic test_flush();
    rsv_en = 1; rsv_addr = 1;
    step();
    rsv_addr = 2;
    step();
    idle();
    #1;
    checks++;
    if (d_bv !== 4'b1110 || d_bc !== 3'd3) begin
      failures++;
      $display("FAIL rsv_three got vec=%b cnt=%0d want 1110/3",
               d_bv, d_bc);
    end
    flush = 1; rsv_en = 1; rsv_addr = 0;
    step();
    idle();
    #1;
    checks++;
    if (d_bv !== 4'b0001 || d_bc !== 3'd1) begin
      failures++;
      $display("FAIL flush_rsv got vec=%b cnt=%0d want 0001/1",
               d_bv, d_bc);
    end
    checks++;
    if (z_bv !== 4'b0000 || z_bc !== 3'd0) begin
      failures++;
      $display("FAIL flush_rsv_z got vec=%b cnt=%0d want 0000/0",
               z_bv, z_bc);
    end
    rd_addr_a = 1; rd_addr_b = 2;
    #1;
    checks++;
    if (d_da !== 8'h3C || d_db !== 8'hA5) begin
      failures++;
      $display("FAIL flush_data got %h/%h want 3c/a5", d_da, d_db);
    end
    flush = 1; wr_en = 1; wr_addr = 2; wr_data = 8'h11;
    step();
    idle();
    #1;
    checks++;
    if (d_bv !== 4'b0000 || d_bc !== 3'd0 ||
        d_db !== 8'h11 || n_db !== 8'h11) begin
      failures++;
      $display("FAIL flush_wr got vec=%b cnt=%0d data=%h/%h want 0000/0/11/11",
               d_bv, d_bc, d_db, n_db);
    end
  endtask

  task automatic test_zero_reg();
    rd_addr_a = 3;
    #1;
    checks++;
    if (z_da !== 8'h7F) begin
      failures++;
      $display("FAIL z_r3 got %h want 7f", z_da);
    end
    rd_addr_a = 0; rd_addr_b = 0;
    wr_en = 1; wr_addr = 0; wr_data = 8'hFF;
    rsv_en = 1; rsv_addr = 0;
    #1;
    checks++;
    if (z_da !== 8'h00 || z_db !== 8'h00 ||
        z_ba !== 1'b0 || z_bb !== 1'b0) begin
      failures++;
      $display("FAIL z_bypass got %h/%h want 00/00", z_da, z_db);
    end
    checks++;
    if (d_da !== 8'hFF) begin
      failures++;
      $display("FAIL r0_bypass got %h want ff", d_da);
    end
    step();
    idle();
    #1;
    checks++;
    if (z_da !== 8'h00 || z_ba !== 1'b0 ||
        z_bv !== 4'b0000 || z_bc !== 3'd0) begin
      failures++;
      $display("FAIL z_after got %h/%b vec=%b cnt=%0d want 00/0/0000/0",
               z_da, z_ba, z_bv, z_bc);
    end
    checks++;
    if (d_da !== 8'hFF || d_ba !== 1'b1 ||
        d_bv !== 4'b0001 || d_bc !== 3'd1) begin
      failures++;
      $display("FAIL r0_after got %h/%b vec=%b cnt=%0d want ff/1/0001/1",
               d_da, d_ba, d_bv, d_bc);
    end
  endtask

  task automatic test_mid_reset();
    rsv_en = 1; rsv_addr = 2;
    step();
    idle();
    #2;
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      rd_addr_a = 2'(i); rd_addr_b = 2'(i);
      #1;
      checks++;
      if (d_da !== 8'h00 || n_db !== 8'h00 ||
          d_ba !== 1'b0 || d_bc !== 3'd0) begin
        failures++;
        $display("FAIL mid_reset[%0d] got %h/%h %b cnt=%0d want 00/00 0 0",
                 i, d_da, n_db, d_ba, d_bc);
      end
    end
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_reserve();
    test_same_edge();
    test_flush();
    test_zero_reg();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised register file for the pipelined CPU core. Two combinational read ports, one writeback port, and optional write-to-read bypass. An integrated per-register busy scoreboard lets the issue stage detect RAW hazards. Sits between decode/issue (reads, reservations) and writeback (writes, busy release).

Parameters:
DATA_W, 8, register width in bits
ADDR_W, 2, register address width; DEPTH = 2**ADDR_W registers
ZERO_REG, 0, 1 = register 0 hardwired to zero (reads 0, writes/reservations ignored, never busy)
BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
rd_addr_a  in  ADDR_W  read port A address
rd_data_a  out  DATA_W  read port A data (combinational)
rd_busy_a  out  1  register at rd_addr_a has a pending write
rd_addr_b  in  ADDR_W  read port B address
rd_data_b  out  DATA_W  read port B data (combinational)
rd_busy_b  out  1  register at rd_addr_b has a pending write
wr_en  in  1  writeback strobe
wr_addr  in  ADDR_W  writeback address
wr_data  in  DATA_W  writeback data
rsv_en  in  1  issue stage reserves a destination register
rsv_addr  in  ADDR_W  register to mark busy
flush  in  1  clear all busy bits (pipeline squash)
busy_vec  out  DEPTH  registered busy bit per register
busy_cnt  out  ADDR_W+1  number of set busy bits (registered)

Behaviour:
- Reset (async, any time incl. mid-operation): all registers = 0, busy_vec = 0, busy_cnt = 0. Read data reflects zeros immediately.
- Write: on rising edge with wr_en=1 -> reg[wr_addr] <= wr_data; busy[wr_addr] cleared. A write to a non-busy register is legal and still updates data.
- Reserve: on rising edge with rsv_en=1 -> busy[rsv_addr] set.
- Same-edge rsv and wr to the same address: data written AND busy stays 1 (new reservation wins).
- flush=1: all busy bits cleared at the edge, register data untouched, wr_en still performs its write. flush with rsv_en same edge: the reservation is applied after the clear (busy[rsv_addr]=1, all others 0).
- Read (combinational, both ports independent, may use same address):
  - BYPASS=1 and wr_en=1 and wr_addr==rd_addr: rd_data = wr_data and rd_busy = 0.
  - Otherwise rd_data = reg[rd_addr] and rd_busy = busy[rd_addr].
  - BYPASS=0: rd_data is always the stored value; the new value becomes visible the cycle after the write.
- ZERO_REG=1: address 0 reads 0 and rd_busy = 0 on both ports; wr_en/rsv_en to address 0 have no effect (including bypass); busy_vec[0] is always 0.
- busy_cnt = popcount(busy_vec) and is updated in the same edge as busy_vec, never combinational from inputs. Max value = DEPTH.
- No internal FSM states beyond storage; there is no latency on reads, and writes/busy changes have 1-cycle latency.

Test Plan:
- Reset then read all addresses on both ports -> rd_data=0x00, rd_busy=0, busy_cnt=0. Assert rst mid-stream after writes -> all zero without a clock edge.
- Write 0xA5 to R2 with rd_addr_a=2 same cycle, BYPASS=1 -> rd_data_a=0xA5 that cycle; BYPASS=0 -> old value 0x00, then 0xA5 next cycle.
- rsv R1 -> next cycle busy_vec=4'b0010, rd_busy_b=1 (rd_addr_b=1), busy_cnt=1; write 0x3C to R1 -> same cycle rd_busy_b=0 with data 0x3C (bypass); next cycle busy_vec=0.
- Same edge rsv_en and wr_en to R3 with wr_data=0x7F -> R3=0x7F, busy_vec[3]=1, busy_cnt=1.
- Reserve R1, R2, R3 (busy_cnt=3), then flush with rsv_en on R0 (ZERO_REG=0) -> busy_vec=4'b0001, busy_cnt=1, data unchanged.
- ZERO_REG=1: write 0xFF to R0 and rsv R0 -> rd_data=0x00, rd_busy=0, busy_vec[0]=0, busy_cnt unchanged.
